// File: rtl/pipeline_control_unit_if.sv
// Signal bundle between the 5-stage pipeline datapath and its stall/flush
// controller.
//   master : pipeline side; drives hazard/memory status, receives enables,
//            flushes, the sticky bus error and the event counters.
//   slave  : controller side (pipeline_control_unit).
// CNT_W sets the width of the three performance counters and must match the
// controller instance.
interface pipeline_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_if_id_i;
    logic [4:0]       rs2_if_id_i;
    logic             uses_rs1_en;
    logic             uses_rs2_en;
    logic [4:0]       rd_id_ex_i;
    logic             mem_read_id_ex_en;
    logic             branch_taken_ex_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;

    logic             pc_write_en_o;
    logic             if_id_write_en_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             ex_mem_write_en_o;
    logic             mem_wb_flush_o;
    logic             bus_error_o;
    logic [CNT_W-1:0] load_use_cnt_o;
    logic [CNT_W-1:0] mem_wait_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output rs1_if_id_i, rs2_if_id_i, uses_rs1_en, uses_rs2_en,
               rd_id_ex_i, mem_read_id_ex_en, branch_taken_ex_i,
               dmem_req_i, dmem_ready_i,
        input  pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o,
               ex_mem_write_en_o, mem_wb_flush_o, bus_error_o,
               load_use_cnt_o, mem_wait_cnt_o, flush_cnt_o
    );

    modport slave (
        input  rs1_if_id_i, rs2_if_id_i, uses_rs1_en, uses_rs2_en,
               rd_id_ex_i, mem_read_id_ex_en, branch_taken_ex_i,
               dmem_req_i, dmem_ready_i,
        output pc_write_en_o, if_id_write_en_o, if_id_flush_o, id_ex_flush_o,
               ex_mem_write_en_o, mem_wb_flush_o, bus_error_o,
               load_use_cnt_o, mem_wait_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken
// branch flushes resolved in EX, and freezes while data memory is not ready.
// A wait-timeout FSM latches a sticky bus error; saturating counters record
// load-use stalls, frozen cycles and branch flushes.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset; also forces enables/flushes to 0
//   pcu    : pipeline_control_unit_if.slave (hazard inputs, enables, flushes,
//            bus_error_o, counters)
//
// state    | meaning
// RUN      | no outstanding unready memory cycle
// MEM_WAIT | memory access pending, counting down to timeout
// ERROR    | timeout reached; pipeline frozen until reset
module pipeline_control_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pipeline_control_unit_if.slave  pcu
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    // The first unready cycle is seen in RUN, so MEM_WAIT has to cover
    // TIMEOUT_CYCLES-1 further cycles; the down-counter reaches zero on the
    // last of them.
    localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 2);

    state_t      state_q, state_d;
    logic [15:0] wait_left_q, wait_left_d;

    logic             load_use;
    logic             mem_stall;
    logic             freeze;
    logic             lu_inc, mw_inc, fl_inc;
    logic [CNT_W-1:0] load_use_cnt_q, mem_wait_cnt_q, flush_cnt_q;

    always_comb begin
        load_use  = pcu.mem_read_id_ex_en && (pcu.rd_id_ex_i != 5'd0) &&
                    ((pcu.uses_rs1_en && (pcu.rd_id_ex_i == pcu.rs1_if_id_i)) ||
                     (pcu.uses_rs2_en && (pcu.rd_id_ex_i == pcu.rs2_if_id_i)));
        mem_stall = pcu.dmem_req_i && !pcu.dmem_ready_i;
        freeze    = (state_q == ERROR) || mem_stall;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_left_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_left_q <= wait_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_left_d = wait_left_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    if (TIMEOUT_CYCLES == 1) begin
                        state_d = ERROR;
                    end else begin
                        state_d     = MEM_WAIT;
                        wait_left_d = WAIT_LOAD;
                    end
                end
            end
            MEM_WAIT: begin
                // ready or a dropped request (abort) both end the wait
                if (!mem_stall) begin
                    state_d     = RUN;
                    wait_left_d = 16'd0;
                end else if (wait_left_q == 16'd0) begin
                    state_d = ERROR;
                end else begin
                    wait_left_d = wait_left_q - 16'd1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d     = RUN;
                wait_left_d = 16'd0;
            end
        endcase
    end

    // Freeze dominates; a taken branch overrides a load-use stall so the
    // target is fetched while both younger stages are flushed.
    always_comb begin
        pcu.pc_write_en_o     = !rst_i && !freeze && (pcu.branch_taken_ex_i || !load_use);
        pcu.if_id_write_en_o  = !rst_i && !freeze && !load_use;
        pcu.if_id_flush_o     = !rst_i && !freeze && pcu.branch_taken_ex_i;
        pcu.id_ex_flush_o     = !rst_i && !freeze && (load_use || pcu.branch_taken_ex_i);
        pcu.ex_mem_write_en_o = !rst_i && !freeze;
        pcu.mem_wb_flush_o    = !rst_i && freeze;
        pcu.bus_error_o       = !rst_i && (state_q == ERROR);
    end

    always_comb begin
        lu_inc = !freeze && load_use && !pcu.branch_taken_ex_i;
        mw_inc = freeze;
        fl_inc = !freeze && pcu.branch_taken_ex_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_use_cnt_q <= '0;
            mem_wait_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (lu_inc && (load_use_cnt_q != '1)) load_use_cnt_q <= load_use_cnt_q + 1'b1;
            if (mw_inc && (mem_wait_cnt_q != '1)) mem_wait_cnt_q <= mem_wait_cnt_q + 1'b1;
            if (fl_inc && (flush_cnt_q != '1))    flush_cnt_q    <= flush_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pcu.load_use_cnt_o = load_use_cnt_q;
        pcu.mem_wait_cnt_o = mem_wait_cnt_q;
        pcu.flush_cnt_o    = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit with a short timeout and narrow
// counters so timeout and saturation are reached quickly. The stimulus process
// drives one cycle at a time and pushes the reference model's expected
// outputs; the monitor pops and compares on every falling edge.
module tb_pipeline_control_unit;

    localparam int T_CYC   = 4;
    localparam int C_W     = 4;
    localparam int CNT_MAX = (1 << C_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_control_unit_if #(.CNT_W(C_W)) bus ();

    pipeline_control_unit #(
        .TIMEOUT_CYCLES(T_CYC),
        .CNT_W         (C_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .pcu  (bus)
    );

    typedef struct packed {
        logic [6:0]     flags; // pc_we, ifid_we, ifid_fl, idex_fl, exmem_we, memwb_fl, bus_err
        logic [C_W-1:0] lu;
        logic [C_W-1:0] mw;
        logic [C_W-1:0] fl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: consecutive unready cycles and a sticky error flag,
    // counters as plain integers clamped at CNT_MAX.
    int m_run, m_lu, m_mw, m_fl;
    bit m_err;

    function automatic int sat_inc(int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic set_idle();
        bus.rs1_if_id_i       = 5'd0;
        bus.rs2_if_id_i       = 5'd0;
        bus.uses_rs1_en       = 1'b0;
        bus.uses_rs2_en       = 1'b0;
        bus.rd_id_ex_i        = 5'd0;
        bus.mem_read_id_ex_en = 1'b0;
        bus.branch_taken_ex_i = 1'b0;
        bus.dmem_req_i        = 1'b0;
        bus.dmem_ready_i      = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.mem_read_id_ex_en = 1'b1;
        bus.rd_id_ex_i        = rd;
        bus.rs1_if_id_i       = rd;
        bus.uses_rs1_en       = 1'b1;
    endtask

    // Applies the current inputs for one cycle.
    task automatic step(input logic r);
        exp_t e;
        bit   lu, fz, br, unready;
        rst = r;
        e   = '0;
        if (r) begin
            m_run = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fl = 0;
        end else begin
            br      = bus.branch_taken_ex_i;
            unready = bus.dmem_req_i && !bus.dmem_ready_i;
            lu = bus.mem_read_id_ex_en && (bus.rd_id_ex_i != 0) &&
                 ((bus.uses_rs1_en && bus.rd_id_ex_i == bus.rs1_if_id_i) ||
                  (bus.uses_rs2_en && bus.rd_id_ex_i == bus.rs2_if_id_i));
            fz = m_err || unready;
            e.flags = {!fz && (br || !lu), !fz && !lu, !fz && br, !fz && (lu || br),
                       !fz, fz, m_err};
            e.lu = C_W'(m_lu);
            e.mw = C_W'(m_mw);
            e.fl = C_W'(m_fl);
            if (!fz && lu && !br) m_lu = sat_inc(m_lu);
            if (fz)               m_mw = sat_inc(m_mw);
            if (!fz && br)        m_fl = sat_inc(m_fl);
            if (!m_err) begin
                if (unready) begin
                    m_run = m_run + 1;
                    if (m_run >= T_CYC) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({bus.pc_write_en_o, bus.if_id_write_en_o, bus.if_id_flush_o, bus.id_ex_flush_o,
                 bus.ex_mem_write_en_o, bus.mem_wb_flush_o, bus.bus_error_o} !== mon_e.flags) begin
                errors++;
                $display("FAIL flags t=%0t actual=%b required=%b", $time,
                         {bus.pc_write_en_o, bus.if_id_write_en_o, bus.if_id_flush_o,
                          bus.id_ex_flush_o, bus.ex_mem_write_en_o, bus.mem_wb_flush_o,
                          bus.bus_error_o}, mon_e.flags);
            end
            checks++;
            if (bus.load_use_cnt_o !== mon_e.lu) begin
                errors++;
                $display("FAIL load_use_cnt t=%0t actual=%0d required=%0d", $time,
                         bus.load_use_cnt_o, mon_e.lu);
            end
            checks++;
            if (bus.mem_wait_cnt_o !== mon_e.mw) begin
                errors++;
                $display("FAIL mem_wait_cnt t=%0t actual=%0d required=%0d", $time,
                         bus.mem_wait_cnt_o, mon_e.mw);
            end
            checks++;
            if (bus.flush_cnt_o !== mon_e.fl) begin
                errors++;
                $display("FAIL flush_cnt t=%0t actual=%0d required=%0d", $time,
                         bus.flush_cnt_o, mon_e.fl);
            end
        end
    end

    initial begin
        set_idle();
        m_run = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fl = 0;
        @(posedge clk);
        #1;
        step(1'b1);
        step(1'b1);

        // load-use: one stall, then the load leaves EX
        set_idle(); set_load_use(5'd5); step(1'b0);
        idle_cycles(1);
        set_idle(); set_load_use(5'd0); step(1'b0);
        set_idle(); set_load_use(5'd5); bus.uses_rs1_en = 1'b0; step(1'b0);
        set_idle(); set_load_use(5'd7); bus.uses_rs1_en = 1'b0;
        bus.uses_rs2_en = 1'b1; bus.rs2_if_id_i = 5'd7; step(1'b0);

        // branch, then branch together with load-use
        set_idle(); bus.branch_taken_ex_i = 1'b1; step(1'b0);
        set_idle(); set_load_use(5'd3); bus.branch_taken_ex_i = 1'b1; step(1'b0);
        idle_cycles(1);

        // 3-cycle memory wait then ready
        set_idle(); bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        bus.dmem_ready_i = 1'b1; step(1'b0);
        idle_cycles(1);

        // branch held across a 2-cycle freeze
        set_idle(); bus.branch_taken_ex_i = 1'b1;
        bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
        step(1'b0); step(1'b0);
        bus.dmem_ready_i = 1'b1; step(1'b0);
        idle_cycles(1);

        // aborted wait (request dropped) followed by a fresh wait
        set_idle(); bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
        step(1'b0); step(1'b0);
        bus.dmem_req_i = 1'b0; step(1'b0);
        bus.dmem_req_i = 1'b1; step(1'b0); step(1'b0); step(1'b0);
        bus.dmem_ready_i = 1'b1; step(1'b0);

        // timeout into ERROR, held after ready, then reset mid-error
        set_idle(); bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0);
        bus.dmem_ready_i = 1'b1; bus.branch_taken_ex_i = 1'b1; step(1'b0);
        set_idle(); set_load_use(5'd9); step(1'b0);
        step(1'b1);
        idle_cycles(2);

        // saturation: 20 load-use stalls
        for (int i = 0; i < 20; i++) begin
            set_idle(); set_load_use(5'(1 + (i % 31))); step(1'b0);
            idle_cycles(1);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            bus.rs1_if_id_i       = 5'($urandom_range(0, 3));
            bus.rs2_if_id_i       = 5'($urandom_range(0, 3));
            bus.uses_rs1_en       = 1'($urandom_range(0, 1));
            bus.uses_rs2_en       = 1'($urandom_range(0, 1));
            bus.rd_id_ex_i        = 5'($urandom_range(0, 3));
            bus.mem_read_id_ex_en = 1'($urandom_range(0, 1));
            bus.branch_taken_ex_i = ($urandom_range(0, 3) == 0);
            bus.dmem_req_i        = 1'($urandom_range(0, 1));
            bus.dmem_ready_i      = ($urandom_range(0, 9) < 6);
            step($urandom_range(0, 63) == 0);
        end

        set_idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d entries left required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
